// File: rtl/y86_pkg.sv
// Shared Y86 definitions: instruction codes, status codes and the sequencer state encoding.
// Imported by the sequencer and by the stage modules.
package y86_pkg;

  localparam logic [3:0] IcodeHalt   = 4'h0;
  localparam logic [3:0] IcodeNop    = 4'h1;
  localparam logic [3:0] IcodeRrmovq = 4'h2;
  localparam logic [3:0] IcodeIrmovq = 4'h3;
  localparam logic [3:0] IcodeRmmovq = 4'h4;
  localparam logic [3:0] IcodeMrmovq = 4'h5;
  localparam logic [3:0] IcodeOpq    = 4'h6;
  localparam logic [3:0] IcodeJxx    = 4'h7;
  localparam logic [3:0] IcodeCall   = 4'h8;
  localparam logic [3:0] IcodeRet    = 4'h9;
  localparam logic [3:0] IcodePushq  = 4'hA;
  localparam logic [3:0] IcodePopq   = 4'hB;

  localparam logic [2:0] StatAok = 3'd1;
  localparam logic [2:0] StatHlt = 3'd2;
  localparam logic [2:0] StatAdr = 3'd3;
  localparam logic [2:0] StatIns = 3'd4;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StDecode,
    StExecute,
    StMemory,
    StWriteback,
    StPcupd,
    StHalted
  } state_e;

  // Instructions that touch data memory and therefore wait on its handshake.
  function automatic logic is_mem_icode(input logic [3:0] icode);
    return icode inside {IcodeRmmovq, IcodeMrmovq, IcodeCall, IcodeRet, IcodePushq, IcodePopq};
  endfunction

endpackage

// File: rtl/y86_next_pc.sv
// Combinational next-PC selection for the sequential Y86 core.
module y86_next_pc
  import y86_pkg::*;
(
  input  logic [3:0]  icode,
  input  logic        cnd,
  input  logic [63:0] valP,
  input  logic [63:0] valC,
  input  logic [63:0] valM,
  output logic [63:0] next_pc
);

  always_comb begin
    next_pc = valP;
    case (icode)
      IcodeJxx:  next_pc = cnd ? valC : valP;
      IcodeCall: next_pc = valC;
      IcodeRet:  next_pc = valM;
      default:   next_pc = valP;
    endcase
  end

endmodule

// File: rtl/seq_stage_ctrl.sv
// Sequencer for a non-pipelined Y86 core: steps one instruction at a time through the stages,
// owns the architectural PC, status and retired-instruction count.
module seq_stage_ctrl
  import y86_pkg::*;
#(
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  icode,
  input  logic        instr_valid,
  input  logic        imem_error,
  input  logic        mem_ready,
  input  logic        dmem_error,
  input  logic        cnd,
  input  logic [63:0] valP,
  input  logic [63:0] valC,
  input  logic [63:0] valM,
  output logic        fetch_en,
  output logic        decode_en,
  output logic        execute_en,
  output logic        mem_en,
  output logic        wb_en,
  output logic [63:0] pc,
  output logic [2:0]  stat,
  output logic        halted,
  output logic [31:0] instr_count
);

  state_e      state_q, state_d;
  logic [63:0] pc_q, pc_d;
  logic [2:0]  stat_q, stat_d;
  logic [31:0] count_q, count_d;
  logic [3:0]  icode_q, icode_d;
  logic        cnd_q, cnd_d;
  logic [63:0] valm_q, valm_d;
  logic [63:0] next_pc;

  y86_next_pc u_next_pc (
    .icode   (icode_q),
    .cnd     (cnd_q),
    .valP    (valP),
    .valC    (valC),
    .valM    (valm_q),
    .next_pc (next_pc)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      pc_q    <= RESET_PC;
      stat_q  <= StatAok;
      count_q <= 32'd0;
      icode_q <= IcodeNop;
      cnd_q   <= 1'b0;
      valm_q  <= 64'd0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      stat_q  <= stat_d;
      count_q <= count_d;
      icode_q <= icode_d;
      cnd_q   <= cnd_d;
      valm_q  <= valm_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    stat_d     = stat_q;
    count_d    = count_q;
    icode_d    = icode_q;
    cnd_d      = cnd_q;
    valm_d     = valm_q;
    fetch_en   = 1'b0;
    decode_en  = 1'b0;
    execute_en = 1'b0;
    mem_en     = 1'b0;
    wb_en      = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) state_d = StFetch;
      end
      StFetch: begin
        fetch_en = 1'b1;
        if (imem_error) begin
          stat_d  = StatAdr;
          state_d = StHalted;
        end else if (instr_valid) begin
          if (icode > IcodePopq) begin
            stat_d  = StatIns;
            state_d = StHalted;
          end else if (icode == IcodeHalt) begin
            // halt retires, so it is counted even though PC does not move
            stat_d  = StatHlt;
            count_d = count_q + 32'd1;
            state_d = StHalted;
          end else begin
            icode_d = icode;
            state_d = StDecode;
          end
        end
      end
      StDecode: begin
        decode_en = 1'b1;
        state_d   = StExecute;
      end
      StExecute: begin
        execute_en = 1'b1;
        cnd_d      = cnd;
        state_d    = StMemory;
      end
      StMemory: begin
        if (is_mem_icode(icode_q)) begin
          mem_en = 1'b1;
          if (dmem_error) begin
            stat_d  = StatAdr;
            state_d = StHalted;
          end else if (mem_ready) begin
            valm_d  = valM;
            state_d = StWriteback;
          end
        end else begin
          valm_d  = valM;
          state_d = StWriteback;
        end
      end
      StWriteback: begin
        wb_en   = 1'b1;
        state_d = StPcupd;
      end
      StPcupd: begin
        pc_d    = next_pc;
        count_d = count_q + 32'd1;
        state_d = StFetch;
      end
      StHalted: begin
        state_d = StHalted;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  assign pc          = pc_q;
  assign stat        = stat_q;
  assign halted      = (state_q == StHalted);
  assign instr_count = count_q;

endmodule
